// File: rtl/fm_cfg_pkg.sv
// fm_cfg_pkg: shared config-vector layout and SPI master state encoding.
package fm_cfg_pkg;
    localparam int N = 18;
    localparam int L = 12;
    localparam int D = 5;
    localparam int CFG_DW = N + L + D + 3 + 3 + 1;
    // Field LSB positions, override bit at the bottom, acc_inc at the top
    localparam int SPI_OVERRIDE_POS   = 0;
    localparam int I2S_WS_ALIGN_POS   = 1;
    localparam int AUDIO_CHAN_SEL_POS = 2;
    localparam int USB_I2SN_POS       = 3;
    localparam int DITH_FACT_POS      = 4;
    localparam int DAC_ENA_POS        = DITH_FACT_POS + D;
    localparam int DF_INC_POS         = DAC_ENA_POS + 3;
    localparam int ACC_INC_POS        = DF_INC_POS + L;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEAD   = 3'd1;
    localparam logic [2:0] S_SCK_HI = 3'd2;
    localparam logic [2:0] S_SCK_LO = 3'd3;
    localparam logic [2:0] S_TRAIL  = 3'd4;
    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        LEAD   = S_LEAD,
        SCK_HI = S_SCK_HI,
        SCK_LO = S_SCK_LO,
        TRAIL  = S_TRAIL
    } spi_state_t;
endpackage

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer: counts 0..CLK_DIV-1 and ticks on the last count of each phase.
module spi_half_period_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] cnt;
    assign tick = cnt == CW'(CLK_DIV - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (clr || tick) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/spi_config_master.sv
// spi_config_master: mode-0 SPI initiator writing one config vector and reading back the old one.
module spi_config_master
    import fm_cfg_pkg::*;
#(
    parameter int DW      = CFG_DW,
    parameter int CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] cfg_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rd_data,
    output logic          spi_clk,
    output logic          spi_csn,
    output logic          spi_mosi,
    input  logic          spi_miso
);
    localparam int BW = $clog2(DW);
    spi_state_t    state;
    logic          tick;
    logic [DW-2:0] tx_shift;
    logic [DW-1:0] rx_shift;
    logic [BW-1:0] bit_cnt;

    spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state == IDLE),
        .tick (tick)
    );

    // MSB already sits on spi_mosi, so tx_shift only holds the remaining bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= '0;
            spi_clk  <= 1'b0;
            spi_csn  <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    tx_shift <= cfg_data[DW-2:0];
                    spi_mosi <= cfg_data[DW-1];
                    spi_csn  <= 1'b0;
                    busy     <= 1'b1;
                    bit_cnt  <= '0;
                    state    <= LEAD;
                end
                LEAD, SCK_LO: if (tick) begin
                    rx_shift <= {rx_shift[DW-2:0], spi_miso};
                    spi_clk  <= 1'b1;
                    state    <= SCK_HI;
                end
                SCK_HI: if (tick) begin
                    spi_clk <= 1'b0;
                    if (bit_cnt == BW'(DW - 1)) begin
                        state <= TRAIL;
                    end else begin
                        tx_shift <= {tx_shift[DW-3:0], 1'b0};
                        spi_mosi <= tx_shift[DW-2];
                        bit_cnt  <= bit_cnt + 1'b1;
                        state    <= SCK_LO;
                    end
                end
                TRAIL: if (tick) begin
                    spi_csn  <= 1'b1;
                    spi_mosi <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    rd_data  <= rx_shift;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
